// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU and LSU result handshakes plus the
// registered writeback port into the register file.
interface writeback_arbiter_if;
   // ALU result source
   logic        alu_valid_i;
   logic        alu_ready_o;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_result_i;

   // LSU result source
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_rd_i;
   logic [31:0] lsu_result_i;

   // Register-file writeback port
   logic        wb_o;
   logic [4:0]  wb_r_o;
   logic [31:0] result_o;
   logic        pending_o;

   // Result producers and register-file observer
   modport master (
      output alu_valid_i, alu_rd_i, alu_result_i,
      output lsu_valid_i, lsu_rd_i, lsu_result_i,
      input  alu_ready_o, lsu_ready_o,
      input  wb_o, wb_r_o, result_o, pending_o
   );

   // The arbiter itself
   modport slave (
      input  alu_valid_i, alu_rd_i, alu_result_i,
      input  lsu_valid_i, lsu_rd_i, lsu_result_i,
      output alu_ready_o, lsu_ready_o,
      output wb_o, wb_r_o, result_o, pending_o
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers ALU and LSU results in per-source FIFOs and
// issues one registered register-file writeback per cycle, round-robin
// between the two sources when both have a result waiting.
module writeback_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   writeback_arbiter_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 5 + 32;

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // last_grant encoding; reset to LSU so the ALU wins the first contest
   localparam logic [0:0] LG_ALU = 1'b0;
   localparam logic [0:0] LG_LSU = 1'b1;

   // ALU FIFO storage and bookkeeping
   logic [EW-1:0] alu_mem [DEPTH];
   logic [AW-1:0] alu_wr_ptr;
   logic [AW-1:0] alu_rd_ptr;
   logic [CW-1:0] alu_count;
   logic          alu_push;
   logic          alu_pop;
   logic          alu_ne;
   logic [EW-1:0] alu_head;

   // LSU FIFO storage and bookkeeping
   logic [EW-1:0] lsu_mem [DEPTH];
   logic [AW-1:0] lsu_wr_ptr;
   logic [AW-1:0] lsu_rd_ptr;
   logic [CW-1:0] lsu_count;
   logic          lsu_push;
   logic          lsu_pop;
   logic          lsu_ne;
   logic [EW-1:0] lsu_head;

   // Arbitration state and selected head
   logic [0:0]    last_grant;
   logic          grant_any;
   logic [EW-1:0] grant_head;

   // A full FIFO refuses a push even when it pops in the same cycle, so
   // ready depends only on the registered count (and reset).
   assign bus.alu_ready_o = !rst && (alu_count != CNT_FULL);
   assign bus.lsu_ready_o = !rst && (lsu_count != CNT_FULL);

   assign alu_push = bus.alu_valid_i && bus.alu_ready_o;
   assign lsu_push = bus.lsu_valid_i && bus.lsu_ready_o;

   assign alu_ne = (alu_count != '0);
   assign lsu_ne = (lsu_count != '0);

   assign alu_head = alu_mem[alu_rd_ptr];
   assign lsu_head = lsu_mem[lsu_rd_ptr];

   assign bus.pending_o = alu_ne || lsu_ne;

   // Round-robin choice between the FIFO heads; the pop is the grant
   always_comb begin
      alu_pop = 1'b0;
      lsu_pop = 1'b0;
      if (alu_ne && lsu_ne) begin
         if (last_grant == LG_LSU) begin
            alu_pop = 1'b1;
         end else begin
            lsu_pop = 1'b1;
         end
      end else if (alu_ne) begin
         alu_pop = 1'b1;
      end else if (lsu_ne) begin
         lsu_pop = 1'b1;
      end
   end

   assign grant_any  = alu_pop || lsu_pop;
   assign grant_head = alu_pop ? alu_head : lsu_head;

   // ALU FIFO storage write; contents need no reset, the count guards them
   always_ff @(posedge clk) begin
      if (alu_push) begin
         alu_mem[alu_wr_ptr] <= {bus.alu_rd_i, bus.alu_result_i};
      end
   end

   // ALU FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_wr_ptr <= '0;
         alu_rd_ptr <= '0;
         alu_count  <= '0;
      end else begin
         if (alu_push) begin
            alu_wr_ptr <= alu_wr_ptr + PTR_ONE;
         end
         if (alu_pop) begin
            alu_rd_ptr <= alu_rd_ptr + PTR_ONE;
         end
         case ({alu_push, alu_pop})
            2'b10:   alu_count <= alu_count + CNT_ONE;
            2'b01:   alu_count <= alu_count - CNT_ONE;
            default: alu_count <= alu_count;
         endcase
      end
   end

   // LSU FIFO storage write; contents need no reset, the count guards them
   always_ff @(posedge clk) begin
      if (lsu_push) begin
         lsu_mem[lsu_wr_ptr] <= {bus.lsu_rd_i, bus.lsu_result_i};
      end
   end

   // LSU FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lsu_wr_ptr <= '0;
         lsu_rd_ptr <= '0;
         lsu_count  <= '0;
      end else begin
         if (lsu_push) begin
            lsu_wr_ptr <= lsu_wr_ptr + PTR_ONE;
         end
         if (lsu_pop) begin
            lsu_rd_ptr <= lsu_rd_ptr + PTR_ONE;
         end
         case ({lsu_push, lsu_pop})
            2'b10:   lsu_count <= lsu_count + CNT_ONE;
            2'b01:   lsu_count <= lsu_count - CNT_ONE;
            default: lsu_count <= lsu_count;
         endcase
      end
   end

   // Remember the most recent winner; idle cycles leave it untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= LG_LSU;
      end else if (alu_pop) begin
         last_grant <= LG_ALU;
      end else if (lsu_pop) begin
         last_grant <= LG_LSU;
      end
   end

   // Registered writeback port; rd/data hold their last value when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.wb_o     <= 1'b0;
         bus.wb_r_o   <= '0;
         bus.result_o <= '0;
      end else begin
         bus.wb_o <= grant_any;
         if (grant_any) begin
            bus.wb_r_o   <= grant_head[EW-1:32];
            bus.result_o <= grant_head[31:0];
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a
// randomized stream, all compared against a queue-based reference model.
module tb_writeback_arbiter;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;

   writeback_arbiter_if bus ();

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: one queue of {rd,data} per source, last winner,
   // and the expected writeback register contents.
   logic [36:0] aq[$];
   logic [36:0] lq[$];
   bit          m_last_lsu;
   logic        m_wb;
   logic [4:0]  m_rd;
   logic [31:0] m_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      aq.delete();
      lq.delete();
      m_last_lsu = 1'b1;
      m_wb  = 1'b0;
      m_rd  = '0;
      m_res = '0;
   endtask

   task automatic idle_inputs();
      bus.alu_valid_i  = 1'b0;
      bus.alu_rd_i     = '0;
      bus.alu_result_i = '0;
      bus.lsu_valid_i  = 1'b0;
      bus.lsu_rd_i     = '0;
      bus.lsu_result_i = '0;
   endtask

   // Pulse reset across one edge and restart the model
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   // One clock cycle: drive sources, check the combinational outputs,
   // advance the model by the arbitration rules, then check the edge.
   task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ares,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] lres,
                        output bit a_acc, output bit l_acc);
      bit a_rdy, l_rdy, g_a, g_l;
      logic [36:0] e;
      bus.alu_valid_i  = av;
      bus.alu_rd_i     = ard;
      bus.alu_result_i = ares;
      bus.lsu_valid_i  = lv;
      bus.lsu_rd_i     = lrd;
      bus.lsu_result_i = lres;
      #1;
      a_rdy = (aq.size() < DEPTH);
      l_rdy = (lq.size() < DEPTH);
      chk("alu_ready", {31'd0, bus.alu_ready_o}, {31'd0, a_rdy});
      chk("lsu_ready", {31'd0, bus.lsu_ready_o}, {31'd0, l_rdy});
      chk("pending", {31'd0, bus.pending_o}, {31'd0, (aq.size() + lq.size()) != 0});
      g_a = (aq.size() != 0) && ((lq.size() == 0) || m_last_lsu);
      g_l = (lq.size() != 0) && !g_a;
      m_wb = g_a || g_l;
      if (g_a) begin
         e = aq.pop_front();
         {m_rd, m_res} = e;
         m_last_lsu = 1'b0;
      end else if (g_l) begin
         e = lq.pop_front();
         {m_rd, m_res} = e;
         m_last_lsu = 1'b1;
      end
      a_acc = av && a_rdy;
      l_acc = lv && l_rdy;
      if (a_acc) aq.push_back({ard, ares});
      if (l_acc) lq.push_back({lrd, lres});
      @(posedge clk);
      #1;
      chk("wb", {31'd0, bus.wb_o}, {31'd0, m_wb});
      chk("wb_r", {27'd0, bus.wb_r_o}, {27'd0, m_rd});
      chk("result", bus.result_o, m_res);
   endtask

   task automatic idle_cycle();
      bit a, l;
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);
   endtask

   initial begin
      bit a_acc, l_acc;
      int seq2[8];
      int lsu_seen;
      bit saw_refuse;
      int ai, li, run;
      bit a_v, l_v;
      logic [4:0]  a_rd, l_rd;
      logic [31:0] a_dat, l_dat;

      seq2 = '{1, 11, 2, 12, 3, 13, 4, 14};

      // Power-up reset state
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb", {31'd0, bus.wb_o}, 32'd0);
      chk("rst_wb_r", {27'd0, bus.wb_r_o}, 32'd0);
      chk("rst_result", bus.result_o, 32'd0);
      chk("rst_pending", {31'd0, bus.pending_o}, 32'd0);
      chk("rst_alu_ready", {31'd0, bus.alu_ready_o}, 32'd0);
      chk("rst_lsu_ready", {31'd0, bus.lsu_ready_o}, 32'd0);
      rst = 1'b0;
      model_clear();
      #1;
      chk("rel_alu_ready", {31'd0, bus.alu_ready_o}, 32'd1);

      // Single ALU result: two-edge latency, then hold
      cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, a_acc, l_acc);
      chk("t1_wb_e1", {31'd0, bus.wb_o}, 32'd0);
      idle_cycle();
      chk("t1_wb_e2", {31'd0, bus.wb_o}, 32'd1);
      chk("t1_rd_e2", {27'd0, bus.wb_r_o}, 32'd5);
      chk("t1_res_e2", bus.result_o, 32'hDEADBEEF);
      idle_cycle();
      chk("t1_wb_e3", {31'd0, bus.wb_o}, 32'd0);
      chk("t1_rd_hold", {27'd0, bus.wb_r_o}, 32'd5);
      chk("t1_res_hold", bus.result_o, 32'hDEADBEEF);

      // Both sources stream from reset: strict alternation, ALU first
      do_reset();
      for (int k = 0; k < 10; k++) begin
         cycle(k < 4, 5'(k + 1), 32'h100 + 32'(k), k < 4, 5'(k + 11), 32'h200 + 32'(k),
               a_acc, l_acc);
         if (k >= 1 && k <= 8) begin
            chk("t2_wb", {31'd0, bus.wb_o}, 32'd1);
            chk("t2_seq", {27'd0, bus.wb_r_o}, 32'(seq2[k-1]));
         end
      end

      // LSU and ALU both stream 10 results: LSU FIFO fills, nothing lost
      do_reset();
      ai = 0;
      li = 0;
      lsu_seen = 0;
      saw_refuse = 1'b0;
      for (int k = 0; k < 40; k++) begin
         cycle(ai < 10, 5'(ai + 1), 32'hC000_0000 + 32'(ai),
               li < 10, 5'(li + 16), 32'hA000_0000 + 32'(li), a_acc, l_acc);
         if (li < 10 && !l_acc) saw_refuse = 1'b1;
         if (a_acc) ai++;
         if (l_acc) li++;
         if (bus.wb_o && bus.wb_r_o >= 5'd16) begin
            chk("t3_lsu_order", {27'd0, bus.wb_r_o}, 32'(16 + lsu_seen));
            chk("t3_lsu_data", bus.result_o, 32'hA000_0000 + 32'(lsu_seen));
            lsu_seen++;
         end
      end
      chk("t3_lsu_refused", {31'd0, saw_refuse}, 32'd1);
      chk("t3_lsu_count", 32'(lsu_seen), 32'd10);

      // rd=0 from the LSU is written back normally
      do_reset();
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, a_acc, l_acc);
      chk("t4_pending", {31'd0, bus.pending_o}, 32'd1);
      idle_cycle();
      chk("t4_wb", {31'd0, bus.wb_o}, 32'd1);
      chk("t4_rd", {27'd0, bus.wb_r_o}, 32'd0);
      chk("t4_res", bus.result_o, 32'h1234);
      chk("t4_pending_fall", {31'd0, bus.pending_o}, 32'd0);
      idle_cycle();
      chk("t4_wb_off", {31'd0, bus.wb_o}, 32'd0);

      // Reset asserted mid-cycle discards everything buffered
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 5'(k + 7), 32'h7700 + 32'(k), 1'b0, 5'd0, 32'd0, a_acc, l_acc);
      end
      idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      chk("t5_wb", {31'd0, bus.wb_o}, 32'd0);
      chk("t5_rd", {27'd0, bus.wb_r_o}, 32'd0);
      chk("t5_res", bus.result_o, 32'd0);
      chk("t5_pending", {31'd0, bus.pending_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      #1;
      chk("t5_alu_ready", {31'd0, bus.alu_ready_o}, 32'd1);
      chk("t5_lsu_ready", {31'd0, bus.lsu_ready_o}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         idle_cycle();
         chk("t5_no_old_wb", {31'd0, bus.wb_o}, 32'd0);
      end

      // ALU alone for 20 cycles: full rate, never back-pressured
      do_reset();
      run = 0;
      for (int k = 0; k < 22; k++) begin
         cycle(k < 20, 5'(k + 1), 32'h5000 + 32'(k * 3), 1'b0, 5'd0, 32'd0, a_acc, l_acc);
         if (k < 20) chk("t6_accept", {31'd0, a_acc}, 32'd1);
         if (k >= 1 && k <= 20) begin
            chk("t6_rd", {27'd0, bus.wb_r_o}, 32'(k));
            if (bus.wb_o) run++;
         end
      end
      chk("t6_run", 32'(run), 32'd20);
      chk("t6_wb_end", {31'd0, bus.wb_o}, 32'd0);

      // Randomized streams with sources holding refused results
      do_reset();
      a_v = 1'b0;
      l_v = 1'b0;
      a_rd = 5'($urandom);
      l_rd = 5'($urandom);
      a_dat = $urandom;
      l_dat = $urandom;
      for (int k = 0; k < 400; k++) begin
         if (!a_v) a_v = ($urandom_range(0, 3) != 0);
         if (!l_v) l_v = ($urandom_range(0, 2) != 0);
         cycle(a_v, a_rd, a_dat, l_v, l_rd, l_dat, a_acc, l_acc);
         if (a_acc) begin
            a_v = 1'b0;
            a_rd = 5'($urandom);
            a_dat = $urandom;
         end
         if (l_acc) begin
            l_v = 1'b0;
            l_rd = 5'($urandom);
            l_dat = $urandom;
         end
         if (k == 200) begin
            do_reset();
            a_v = 1'b0;
            l_v = 1'b0;
         end
      end
      for (int k = 0; k < 12; k++) idle_cycle();
      chk("rand_drained", {31'd0, bus.pending_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
